// File: rtl/huff_pkg.sv
// Shared types and defaults for the canonical Huffman decode sequencer.
package huff_pkg;
  localparam int DEF_MAX_LEN = 16;
  localparam int DEF_CNT_W   = 9;

  localparam logic CFG_COUNT = 1'b0;
  localparam logic CFG_SYM   = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_LOOKUP,
    S_EMIT,
    S_FINISH,
    S_ERROR
  } state_e;
endpackage

// File: rtl/huff_sym_ram.sv
// Symbol table: one write port from configuration, one registered read port.
module huff_sym_ram #(
  parameter int NSYM  = 256,
  parameter int SYM_W = 8,
  parameter int AW    = $clog2(NSYM)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [SYM_W-1:0] rdata
);
  logic [SYM_W-1:0] mem_q [NSYM];
  logic [SYM_W-1:0] rdata_d, rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read data holds between reads so the emitted symbol stays stable under backpressure.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/huff_decode_sched.sv
// Bit-serial canonical Huffman decoder: pulls bytes, walks codes MSB first against
// a per-length count table, looks up the symbol and emits one symbol per code.
module huff_decode_sched
  import huff_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int SYM_W   = 8,
  parameter int NSYM    = 256,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [7:0]       cfg_addr,
  input  logic [15:0]      cfg_wdata,
  input  logic             start,
  input  logic [15:0]      num_symbols,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SYM_W-1:0] out_sym,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int AW     = CNT_W + MAX_LEN;
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int RAM_AW = $clog2(NSYM);

  state_e state_q, state_d;
  logic [15:0]       rem_q, rem_d;
  logic [7:0]        sh_q, sh_d;
  logic [3:0]        bits_q, bits_d;
  logic [AW-1:0]     code_q, code_d, first_q, first_d, index_q, index_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic              done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q [1:MAX_LEN];
  logic [CNT_W-1:0]  cnt_d [1:MAX_LEN];

  logic [CNT_W-1:0]  cnt_cur;
  logic [AW-1:0]     code_cur, offset;
  logic              hit, len_max, cfg_ok;
  logic              unused_cfg;

  assign unused_cfg = ^cfg_wdata[15:CNT_W];
  assign cfg_ok     = cfg_we && (state_q == S_IDLE);

  always_comb begin
    cnt_cur = '0;
    for (int i = 1; i <= MAX_LEN; i++) begin
      if (len_q == LEN_W'(i)) cnt_cur = cnt_q[i];
    end
    code_cur = code_q | AW'(sh_q[7]);
    offset   = code_cur - first_q;
    hit      = offset < AW'(cnt_cur);
    len_max  = len_q == LEN_W'(MAX_LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_symbols == '0) ? S_FINISH : S_FETCH;
      S_FETCH:  if (in_valid) state_d = S_DECODE;
      S_DECODE: begin
        if (hit)                  state_d = S_LOOKUP;
        else if (len_max)         state_d = S_ERROR;
        else if (bits_q == 4'd1)  state_d = S_FETCH;
      end
      S_LOOKUP: state_d = S_EMIT;
      S_EMIT: begin
        if (out_ready) begin
          if (rem_q == 16'd1)      state_d = S_FINISH;
          else if (bits_q == '0)   state_d = S_FETCH;
          else                     state_d = S_DECODE;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = state_q == S_FETCH;
    out_valid = state_q == S_EMIT;
    busy      = (state_q != S_IDLE) && (state_q != S_ERROR);
    done      = done_q;
    err       = err_q;
  end

  always_comb begin
    rem_d   = rem_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    code_d  = code_q;
    first_d = first_q;
    index_d = index_q;
    len_d   = len_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        rem_d   = num_symbols;
        sh_d    = '0;
        bits_d  = '0;
        err_d   = 1'b0;
        code_d  = '0;
        first_d = '0;
        index_d = '0;
        len_d   = LEN_W'(1);
      end
      S_FETCH: if (in_valid) begin
        sh_d   = in_data;
        bits_d = 4'd8;
      end
      S_DECODE: begin
        sh_d   = sh_q << 1;
        bits_d = bits_q - 4'd1;
        if (hit) begin
          addr_d  = RAM_AW'(index_q + offset);
          code_d  = '0;
          first_d = '0;
          index_d = '0;
          len_d   = LEN_W'(1);
        end else begin
          // Step to the next length: canonical first code doubles after skipping this length's codes.
          index_d = index_q + AW'(cnt_cur);
          first_d = (first_q + AW'(cnt_cur)) << 1;
          code_d  = code_cur << 1;
          len_d   = len_q + LEN_W'(1);
          if (len_max) err_d = 1'b1;
        end
      end
      S_EMIT:   if (out_ready) rem_d = rem_q - 16'd1;
      S_FINISH: done_d = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    for (int i = 1; i <= MAX_LEN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cfg_ok && cfg_sel == CFG_COUNT && cfg_addr == 8'(i)) cnt_d[i] = cfg_wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      sh_q    <= '0;
      bits_q  <= '0;
      code_q  <= '0;
      first_q <= '0;
      index_q <= '0;
      len_q   <= LEN_W'(1);
      addr_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 1; i <= MAX_LEN; i++) cnt_q[i] <= '0;
    end else begin
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
      code_q  <= code_d;
      first_q <= first_d;
      index_q <= index_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int i = 1; i <= MAX_LEN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  huff_sym_ram #(.NSYM(NSYM), .SYM_W(SYM_W), .AW(RAM_AW)) u_sym_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_ok && cfg_sel == CFG_SYM),
    .waddr (cfg_addr[RAM_AW-1:0]),
    .wdata (cfg_wdata[SYM_W-1:0]),
    .re    (state_q == S_LOOKUP),
    .raddr (addr_q),
    .rdata (out_sym)
  );
endmodule
